bp_cce_inst_fetch: RTL and testbench
====================================

Name: bp_cce_inst_fetch

Overview:
- Microcode fetch stage for the CCE. It holds the fetch PC and the synchronous-read instruction RAM, and presents one instruction per cycle to decode/execute.
- It consumes the CCE stall signal: a stalled instruction is held and replayed unchanged.
- It consumes branch resolution from execute: a mispredict squashes the in-flight fetch and redirects the PC.
- Microcode is loaded through a config write port while fetch is disabled.

Parameters:
- inst_ram_els_p, 256, instruction RAM depth; power of two, minimum 4.
- inst_width_p, 48, microcode instruction width.
- pc_width_lp, $clog2(inst_ram_els_p), PC width (derived).

Ports:
- clk_i  in  1  clock.
- reset_n_i  in  1  asynchronous, active-low reset.
- ucode_en_i  in  1  1 = fetch/execute enabled; 0 = load mode.
- cfg_w_v_i  in  1  config write valid.
- cfg_addr_i  in  pc_width_lp  config write address.
- cfg_data_i  in  inst_width_p  config write data.
- cfg_w_yumi_o  out  1  config write accepted this cycle.
- stall_i  in  1  stall from the CCE stall unit for the current instruction.
- mispredict_i  in  1  current instruction resolved a taken branch/redirect.
- mispredict_pc_i  in  pc_width_lp  redirect target.
- inst_o  out  inst_width_p  current instruction.
- inst_v_o  out  1  inst_o is valid.
- pc_o  out  pc_width_lp  PC of inst_o.

Behaviour:
- Reset values: inst_v_o=0, inst_o=0, pc_o=0, cfg_w_yumi_o=0, fetch_pc=0, state=e_load.

State machine (3 states):
- e_load:
  - cfg_w_yumi_o = cfg_w_v_i; writes RAM[cfg_addr_i] on the same edge.
  - inst_v_o=0.
  - ucode_en_i=1 and cfg_w_v_i=0 -> e_prime. A simultaneous write stays in e_load and completes first.
- e_prime:
  - Issue RAM read of fetch_pc (=0). fetch_pc <= 1. Go to e_fetch.
  - inst_v_o=0 this cycle.
- e_fetch:
  - The read issued in the previous cycle appears as inst_o, with pc_o equal to its address and inst_v_o=1.
  - cfg_w_yumi_o=0; config writes are held off, not dropped.
- First valid instruction: 2 cycles after ucode_en_i is sampled high.

Advance in e_fetch, priority order:
- ucode_en_i=0 -> e_load. Next cycle inst_v_o=0 and fetch_pc=0. Any in-flight read is discarded.
- stall_i=1 -> RAM read enable low. inst_o, pc_o, inst_v_o and fetch_pc are held. mispredict_i is ignored (the instruction did not execute).
- mispredict_i=1 -> issue read of mispredict_pc_i, fetch_pc <= mispredict_pc_i+1. Next cycle inst_v_o=0 (one-cycle bubble). The cycle after, inst_o=RAM[mispredict_pc_i].
- Otherwise -> issue read of fetch_pc, fetch_pc <= fetch_pc+1.

Arithmetic and bubbles:
- PC arithmetic is modulo inst_ram_els_p: PC inst_ram_els_p-1 wraps to 0 without a flag.
- Bubble rule: when inst_v_o=0, stall_i and mispredict_i are don't-care. Fetch advances, so the bubble never stalls.

Reset and output register:
- Reset asserted mid-operation clears state immediately (asynchronous). RAM contents are not cleared.
- inst_o comes from an output register: RAM read data is captured into it on every non-stalled cycle. Under stall the register is not reloaded, so the output is stable regardless of RAM read-data behaviour.

Decomposition:
- bp_me_pkg owns:
  - bp_cce_inst_fetch_state_e: e_load, e_prime, e_fetch.
  - The instruction width constant, shared with the decoder.
- One sub-module: bp_cce_inst_ram, a 1R1W synchronous-read RAM wrapper (read enable, write enable, shared clock).
  - Write and read on one port-pair. A write and a read never occur in the same state, so no bypass logic is needed.

Test Plan:
- Load RAM[0..3]=A,B,C,D, raise ucode_en_i, stall_i=0 -> inst_v_o rises 2 cycles later. Then (pc_o,inst_o)=(0,A),(1,B),(2,C),(3,D) on consecutive cycles.
- During the pc_o=1 instruction, hold stall_i=1 for 3 cycles -> inst_o=B, pc_o=1 for 4 cycles total. Next cycle pc_o=2, inst_o=C.
- At pc_o=2, pulse mispredict_i with mispredict_pc_i=0 -> one cycle inst_v_o=0, then pc_o=0 inst_o=A, then pc_o=1. Repeat with stall_i=1 and mispredict_i=1 together -> mispredict ignored, instruction replayed.
- inst_ram_els_p=4, run straight-line -> pc_o sequence 3,0,1 with no bubble.
- Assert cfg_w_v_i while in e_fetch -> cfg_w_yumi_o=0, RAM unchanged. Drop ucode_en_i -> inst_v_o=0 next cycle, write accepted (yumi=1). Re-enable -> fetch restarts at pc 0 with the new data.
- Assert reset_n_i=0 asynchronously mid-fetch (between edges) -> inst_v_o=0 and pc_o=0 immediately. After release, state=e_load and the previously loaded microcode still executes from pc 0.

Source files
------------

// File: rtl/bp_me_pkg.sv
// Shared types and constants for the CCE microcode engine.
package bp_me_pkg;

    localparam int bp_cce_inst_width_gp = 48;

    typedef enum logic [1:0] {
        e_load  = 2'd0,
        e_prime = 2'd1,
        e_fetch = 2'd2
    } bp_cce_inst_fetch_state_e;

endpackage

// File: rtl/bp_cce_inst_ram.sv
// Microcode store: 1R1W RAM with a registered read port that holds its data
// whenever read enable is low.
module bp_cce_inst_ram
    import bp_me_pkg::*;
#(
    parameter int els_p   = 256,
    parameter int width_p = bp_cce_inst_width_gp,
    localparam int addr_width_lp = $clog2(els_p)
) (
    input  logic                     clk_i,
    input  logic                     w_v_i,
    input  logic [addr_width_lp-1:0] w_addr_i,
    input  logic [width_p-1:0]       w_data_i,
    input  logic                     r_v_i,
    input  logic [addr_width_lp-1:0] r_addr_i,
    output logic [width_p-1:0]       r_data_o
);

    logic [width_p-1:0] mem_q [els_p];
    logic [width_p-1:0] r_data_q;
    logic [width_p-1:0] r_data_d;

    always_comb begin
        r_data_d = r_data_q;
        if (r_v_i) begin
            r_data_d = mem_q[r_addr_i];
        end
    end

    // Reads and writes are never issued in the same fetch state, so no bypass.
    always_ff @(posedge clk_i) begin
        if (w_v_i) begin
            mem_q[w_addr_i] <= w_data_i;
        end
        r_data_q <= r_data_d;
    end

    assign r_data_o = r_data_q;

endmodule

// File: rtl/bp_cce_inst_fetch.sv
// CCE microcode fetch: PC, instruction RAM and a registered instruction
// output with stall replay and mispredict redirect.
module bp_cce_inst_fetch
    import bp_me_pkg::*;
#(
    parameter int inst_ram_els_p = 256,
    parameter int inst_width_p   = bp_cce_inst_width_gp,
    localparam int pc_width_lp   = $clog2(inst_ram_els_p)
) (
    input  logic                    clk_i,
    input  logic                    reset_n_i,
    input  logic                    ucode_en_i,
    input  logic                    cfg_w_v_i,
    input  logic [pc_width_lp-1:0]  cfg_addr_i,
    input  logic [inst_width_p-1:0] cfg_data_i,
    output logic                    cfg_w_yumi_o,
    input  logic                    stall_i,
    input  logic                    mispredict_i,
    input  logic [pc_width_lp-1:0]  mispredict_pc_i,
    output logic [inst_width_p-1:0] inst_o,
    output logic                    inst_v_o,
    output logic [pc_width_lp-1:0]  pc_o
);

    bp_cce_inst_fetch_state_e state_q, state_d;
    logic [pc_width_lp-1:0]   fetch_pc_q, fetch_pc_d;
    logic [pc_width_lp-1:0]   rd_pc_q, rd_pc_d;
    logic [inst_width_p-1:0]  inst_q, inst_d;
    logic                     inst_v_q, inst_v_d;
    logic [pc_width_lp-1:0]   pc_q, pc_d;

    logic                     ram_r_v;
    logic [pc_width_lp-1:0]   ram_r_addr;
    logic [inst_width_p-1:0]  ram_r_data;
    logic                     cfg_w_yumi;

    assign cfg_w_yumi = reset_n_i & (state_q == e_load) & cfg_w_v_i;

    bp_cce_inst_ram #(
        .els_p   (inst_ram_els_p),
        .width_p (inst_width_p)
    ) inst_ram (
        .clk_i    (clk_i),
        .w_v_i    (cfg_w_yumi),
        .w_addr_i (cfg_addr_i),
        .w_data_i (cfg_data_i),
        .r_v_i    (ram_r_v),
        .r_addr_i (ram_r_addr),
        .r_data_o (ram_r_data)
    );

    // rd_pc tracks the address sitting in the RAM read register (the in-flight fetch).
    always_comb begin
        state_d    = state_q;
        fetch_pc_d = fetch_pc_q;
        rd_pc_d    = rd_pc_q;
        inst_d     = inst_q;
        inst_v_d   = inst_v_q;
        pc_d       = pc_q;
        ram_r_v    = 1'b0;
        ram_r_addr = fetch_pc_q;

        case (state_q)
            e_load: begin
                inst_v_d   = 1'b0;
                fetch_pc_d = '0;
                if (ucode_en_i && !cfg_w_v_i) begin
                    state_d = e_prime;
                end
            end
            e_prime: begin
                ram_r_v    = 1'b1;
                ram_r_addr = fetch_pc_q;
                rd_pc_d    = fetch_pc_q;
                fetch_pc_d = fetch_pc_q + pc_width_lp'(1);
                inst_v_d   = 1'b0;
                state_d    = e_fetch;
            end
            e_fetch: begin
                if (!ucode_en_i) begin
                    state_d    = e_load;
                    inst_v_d   = 1'b0;
                    fetch_pc_d = '0;
                end else if (!(inst_v_q && stall_i)) begin
                    // A bubble never stalls or redirects; it always advances.
                    ram_r_v  = 1'b1;
                    inst_d   = ram_r_data;
                    pc_d     = rd_pc_q;
                    inst_v_d = 1'b1;
                    if (inst_v_q && mispredict_i) begin
                        inst_v_d   = 1'b0;
                        ram_r_addr = mispredict_pc_i;
                        rd_pc_d    = mispredict_pc_i;
                        fetch_pc_d = mispredict_pc_i + pc_width_lp'(1);
                    end else begin
                        ram_r_addr = fetch_pc_q;
                        rd_pc_d    = fetch_pc_q;
                        fetch_pc_d = fetch_pc_q + pc_width_lp'(1);
                    end
                end
            end
            default: begin
                state_d = e_load;
            end
        endcase
    end

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            state_q    <= e_load;
            fetch_pc_q <= '0;
            rd_pc_q    <= '0;
            inst_q     <= '0;
            inst_v_q   <= 1'b0;
            pc_q       <= '0;
        end else begin
            state_q    <= state_d;
            fetch_pc_q <= fetch_pc_d;
            rd_pc_q    <= rd_pc_d;
            inst_q     <= inst_d;
            inst_v_q   <= inst_v_d;
            pc_q       <= pc_d;
        end
    end

    assign cfg_w_yumi_o = cfg_w_yumi;
    assign inst_o       = inst_q;
    assign inst_v_o     = inst_v_q;
    assign pc_o         = pc_q;

endmodule

// File: tb/tb_bp_cce_inst_fetch.sv
// Self-checking bench for bp_cce_inst_fetch: vector table plus scoreboard queue,
// with a reduced-depth instance for PC wraparound.
module tb_bp_cce_inst_fetch;
    import bp_me_pkg::*;

    localparam int iw_lp  = bp_cce_inst_width_gp;
    localparam int pcw_lp = 8;

    localparam logic [iw_lp-1:0] da = 48'h1111_0000_000A;
    localparam logic [iw_lp-1:0] db = 48'h2222_0000_000B;
    localparam logic [iw_lp-1:0] dc = 48'h3333_0000_000C;
    localparam logic [iw_lp-1:0] dd = 48'h4444_0000_000D;
    localparam logic [iw_lp-1:0] n0 = 48'h5A5A_5A5A_5A5A;
    localparam logic [iw_lp-1:0] n2 = 48'hDEAD_BEEF_0002;
    localparam logic [iw_lp-1:0] n3 = 48'hC0DE_0000_0033;

    logic              clk = 1'b0;
    logic              reset_n;
    logic              ucode_en, cfg_w_v, cfg_w_yumi, stall, mispredict, inst_v;
    logic [pcw_lp-1:0] cfg_addr, mispredict_pc, pc;
    logic [iw_lp-1:0]  cfg_data, inst;

    logic              sm_ucode_en, sm_cfg_w_v, sm_cfg_w_yumi, sm_stall, sm_mispredict, sm_inst_v;
    logic [1:0]        sm_cfg_addr, sm_mispredict_pc, sm_pc;
    logic [iw_lp-1:0]  sm_cfg_data, sm_inst;

    int tests_run    = 0;
    int tests_failed = 0;

    typedef struct packed {
        logic              en;
        logic              stall;
        logic              mp;
        logic [pcw_lp-1:0] mpc;
        logic              cfg_v;
        logic [pcw_lp-1:0] cfg_addr;
        logic [iw_lp-1:0]  cfg_data;
        logic              exp_yumi;
        logic              exp_v;
        logic [pcw_lp-1:0] exp_pc;
    } vec_t;

    typedef struct packed {
        logic              v;
        logic [pcw_lp-1:0] pc;
        logic [iw_lp-1:0]  inst;
    } exp_t;

    vec_t             vecs [33];
    vec_t             rst_vecs [5];
    exp_t             exp_q [$];
    logic [iw_lp-1:0] img [256];
    logic [iw_lp-1:0] sm_img [4];

    always #5 clk = ~clk;

    bp_cce_inst_fetch dut (
        .clk_i           (clk),
        .reset_n_i       (reset_n),
        .ucode_en_i      (ucode_en),
        .cfg_w_v_i       (cfg_w_v),
        .cfg_addr_i      (cfg_addr),
        .cfg_data_i      (cfg_data),
        .cfg_w_yumi_o    (cfg_w_yumi),
        .stall_i         (stall),
        .mispredict_i    (mispredict),
        .mispredict_pc_i (mispredict_pc),
        .inst_o          (inst),
        .inst_v_o        (inst_v),
        .pc_o            (pc)
    );

    bp_cce_inst_fetch #(.inst_ram_els_p(4)) dut_small (
        .clk_i           (clk),
        .reset_n_i       (reset_n),
        .ucode_en_i      (sm_ucode_en),
        .cfg_w_v_i       (sm_cfg_w_v),
        .cfg_addr_i      (sm_cfg_addr),
        .cfg_data_i      (sm_cfg_data),
        .cfg_w_yumi_o    (sm_cfg_w_yumi),
        .stall_i         (sm_stall),
        .mispredict_i    (sm_mispredict),
        .mispredict_pc_i (sm_mispredict_pc),
        .inst_o          (sm_inst),
        .inst_v_o        (sm_inst_v),
        .pc_o            (sm_pc)
    );

    function automatic vec_t mk(input logic en, input logic st, input logic mp,
                                input logic [pcw_lp-1:0] mpc, input logic cv,
                                input logic [pcw_lp-1:0] ca, input logic [iw_lp-1:0] cd,
                                input logic ey, input logic ev, input logic [pcw_lp-1:0] ep);
        vec_t v;
        v.en = en; v.stall = st; v.mp = mp; v.mpc = mpc;
        v.cfg_v = cv; v.cfg_addr = ca; v.cfg_data = cd;
        v.exp_yumi = ey; v.exp_v = ev; v.exp_pc = ep;
        return v;
    endfunction

    task automatic check_output(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests_run++;
        if (act !== exp) begin
            tests_failed++;
            $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // Drive one cycle of inputs, check the accept flag before the edge, then
    // compare the post-edge outputs against the scoreboard entry.
    task automatic apply_stimulus(input vec_t v, input int idx);
        exp_t e;
        @(negedge clk);
        ucode_en      = v.en;
        stall         = v.stall;
        mispredict    = v.mp;
        mispredict_pc = v.mpc;
        cfg_w_v       = v.cfg_v;
        cfg_addr      = v.cfg_addr;
        cfg_data      = v.cfg_data;
        #1;
        check_output($sformatf("yumi[%0d]", idx), 64'(cfg_w_yumi), 64'(v.exp_yumi));
        if (v.exp_yumi) img[v.cfg_addr] = v.cfg_data;
        exp_q.push_back('{v: v.exp_v, pc: v.exp_pc, inst: img[v.exp_pc]});
        @(posedge clk);
        #1;
        e = exp_q.pop_front();
        check_output($sformatf("inst_v[%0d]", idx), 64'(inst_v), 64'(e.v));
        if (e.v) begin
            check_output($sformatf("pc[%0d]", idx), 64'(pc), 64'(e.pc));
            check_output($sformatf("inst[%0d]", idx), 64'(inst), 64'(e.inst));
        end
    endtask

    initial begin
        reset_n = 1'b0;
        ucode_en = 1'b0; cfg_w_v = 1'b0; cfg_addr = '0; cfg_data = '0;
        stall = 1'b0; mispredict = 1'b0; mispredict_pc = '0;
        sm_ucode_en = 1'b0; sm_cfg_w_v = 1'b0; sm_cfg_addr = '0; sm_cfg_data = '0;
        sm_stall = 1'b0; sm_mispredict = 1'b0; sm_mispredict_pc = '0;
        for (int i = 0; i < 256; i++) img[i] = '0;
        sm_img[0] = 48'hABCD_0000_0000; sm_img[1] = 48'hABCD_0000_0011;
        sm_img[2] = 48'hABCD_0000_0022; sm_img[3] = 48'hABCD_0000_0033;

        //            en st mp mpc cv ca  data ey ev pc
        vecs[0]  = mk(0, 0, 0, 0,  1, 0,  da,  1, 0, 0);
        vecs[1]  = mk(0, 0, 0, 0,  1, 1,  db,  1, 0, 0);
        vecs[2]  = mk(0, 0, 0, 0,  1, 2,  dc,  1, 0, 0);
        vecs[3]  = mk(0, 0, 0, 0,  1, 3,  dd,  1, 0, 0);
        vecs[4]  = mk(1, 0, 0, 0,  0, 0,  '0,  0, 0, 0);
        vecs[5]  = mk(1, 0, 0, 0,  0, 0,  '0,  0, 0, 0);
        vecs[6]  = mk(1, 0, 0, 0,  0, 0,  '0,  0, 1, 0);
        vecs[7]  = mk(1, 0, 0, 0,  0, 0,  '0,  0, 1, 1);
        vecs[8]  = mk(1, 1, 0, 0,  0, 0,  '0,  0, 1, 1);
        vecs[9]  = mk(1, 1, 0, 0,  0, 0,  '0,  0, 1, 1);
        vecs[10] = mk(1, 1, 0, 0,  0, 0,  '0,  0, 1, 1);
        vecs[11] = mk(1, 0, 0, 0,  0, 0,  '0,  0, 1, 2);
        vecs[12] = mk(1, 0, 1, 0,  0, 0,  '0,  0, 0, 0);
        vecs[13] = mk(1, 0, 0, 0,  0, 0,  '0,  0, 1, 0);
        vecs[14] = mk(1, 0, 0, 0,  0, 0,  '0,  0, 1, 1);
        vecs[15] = mk(1, 0, 0, 0,  0, 0,  '0,  0, 1, 2);
        vecs[16] = mk(1, 1, 1, 0,  0, 0,  '0,  0, 1, 2);
        vecs[17] = mk(1, 0, 0, 0,  0, 0,  '0,  0, 1, 3);
        vecs[18] = mk(1, 0, 1, 3,  0, 0,  '0,  0, 0, 0);
        vecs[19] = mk(1, 1, 1, 1,  0, 0,  '0,  0, 1, 3);
        vecs[20] = mk(1, 0, 1, 1,  0, 0,  '0,  0, 0, 0);
        vecs[21] = mk(1, 0, 0, 0,  0, 0,  '0,  0, 1, 1);
        vecs[22] = mk(1, 0, 0, 0,  0, 0,  '0,  0, 1, 2);
        vecs[23] = mk(1, 0, 0, 0,  1, 2,  n2,  0, 1, 3);
        vecs[24] = mk(0, 0, 0, 0,  1, 2,  n2,  0, 0, 0);
        vecs[25] = mk(0, 0, 0, 0,  1, 0,  n0,  1, 0, 0);
        vecs[26] = mk(1, 0, 0, 0,  1, 3,  n3,  1, 0, 0);
        vecs[27] = mk(1, 0, 0, 0,  0, 0,  '0,  0, 0, 0);
        vecs[28] = mk(1, 0, 0, 0,  0, 0,  '0,  0, 0, 0);
        vecs[29] = mk(1, 0, 0, 0,  0, 0,  '0,  0, 1, 0);
        vecs[30] = mk(1, 0, 0, 0,  0, 0,  '0,  0, 1, 1);
        vecs[31] = mk(1, 0, 0, 0,  0, 0,  '0,  0, 1, 2);
        vecs[32] = mk(1, 0, 0, 0,  0, 0,  '0,  0, 1, 3);

        rst_vecs[0] = mk(0, 0, 0, 0, 1, 3, n3, 1, 0, 0);
        rst_vecs[1] = mk(1, 0, 0, 0, 0, 0, '0, 0, 0, 0);
        rst_vecs[2] = mk(1, 0, 0, 0, 0, 0, '0, 0, 0, 0);
        rst_vecs[3] = mk(1, 0, 0, 0, 0, 0, '0, 0, 1, 0);
        rst_vecs[4] = mk(1, 0, 0, 0, 0, 0, '0, 0, 1, 1);

        repeat (2) @(posedge clk);
        #1;
        check_output("reset_inst_v", 64'(inst_v), 64'(0));
        check_output("reset_inst", 64'(inst), 64'(0));
        check_output("reset_pc", 64'(pc), 64'(0));
        check_output("reset_yumi", 64'(cfg_w_yumi), 64'(0));
        @(negedge clk);
        reset_n = 1'b1;

        for (int i = 0; i < 33; i++) apply_stimulus(vecs[i], i);

        // Asynchronous reset landing between edges while fetching.
        @(posedge clk);
        #2;
        reset_n = 1'b0;
        #1;
        check_output("midrst_inst_v", 64'(inst_v), 64'(0));
        check_output("midrst_pc", 64'(pc), 64'(0));
        check_output("midrst_inst", 64'(inst), 64'(0));
        @(negedge clk);
        ucode_en = 1'b0; cfg_w_v = 1'b0; stall = 1'b0; mispredict = 1'b0;
        @(negedge clk);
        reset_n = 1'b1;
        for (int i = 0; i < 5; i++) apply_stimulus(rst_vecs[i], 100 + i);

        // Four-entry instance: straight-line fetch must wrap 3 -> 0 with no bubble.
        @(negedge clk);
        ucode_en = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            sm_cfg_w_v  = 1'b1;
            sm_cfg_addr = 2'(i);
            sm_cfg_data = sm_img[i];
            #1;
            check_output($sformatf("sm_yumi[%0d]", i), 64'(sm_cfg_w_yumi), 64'(1));
        end
        @(negedge clk);
        sm_cfg_w_v  = 1'b0;
        sm_ucode_en = 1'b1;
        for (int i = 0; i < 8; i++) begin
            logic [1:0] exp_pc;
            @(posedge clk);
            #1;
            check_output($sformatf("sm_inst_v[%0d]", i), 64'(sm_inst_v), 64'(i >= 2));
            if (i >= 2) begin
                exp_pc = 2'(i - 2);
                check_output($sformatf("sm_pc[%0d]", i), 64'(sm_pc), 64'(exp_pc));
                check_output($sformatf("sm_inst[%0d]", i), 64'(sm_inst), 64'(sm_img[exp_pc]));
            end
        end

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
